// File: rtl/ifetch_stage_pkg.sv
// Shared encodings for the instruction-fetch stage.
// Jump kinds, bubble constants and fetch FSM states.
package ifetch_stage_pkg;

  typedef enum logic [1:0] {
    JT_NONE = 2'b00,
    JT_BR   = 2'b01,
    JT_J    = 2'b10,
    JT_JR   = 2'b11
  } jump_type_e;

  localparam logic [5:0] NOP_OPCODE_C = 6'h00;
  localparam logic [5:0] NOP_FUNCT_C  = 6'h15;

  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_HELD  = 2'd1,
    ST_DROP  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/ifetch_target_gen.sv
// Redirect decision and target address for fetch.
// Offsets are byte offsets added to Decode's PC+4.
module ifetch_target_gen
  import ifetch_stage_pkg::*;
(
  input  logic [1:0]  i_jump_type,
  input  logic        i_cond_src,
  input  logic        i_branch_cond,
  input  logic        i_branch_result,
  input  logic        i_fp_cond,
  input  logic [31:0] i_pc_plus4,
  input  logic [15:0] i_imm16,
  input  logic [25:0] i_imm26,
  input  logic [31:0] i_jr_data,
  output logic        o_taken,
  output logic [31:0] o_target
);

  jump_type_e w_jt;
  logic       w_cond;

  assign w_jt   = jump_type_e'(i_jump_type);
  assign w_cond = i_cond_src ? i_fp_cond : i_branch_result;

  // Select taken flag and target by jump kind
  always_comb begin
    o_taken  = 1'b0;
    o_target = i_pc_plus4;
    unique case (w_jt)
      JT_NONE: begin
        o_taken  = 1'b0;
        o_target = i_pc_plus4;
      end
      JT_BR: begin
        o_taken  = (w_cond == i_branch_cond);
        o_target = i_pc_plus4
                 + {{16{i_imm16[15]}}, i_imm16};
      end
      JT_J: begin
        o_taken  = 1'b1;
        o_target = i_pc_plus4
                 + {{6{i_imm26[25]}}, i_imm26};
      end
      JT_JR: begin
        o_taken  = 1'b1;
        o_target = i_jr_data;
      end
    endcase
  end

endmodule

// File: rtl/ifetch_stage.sv
// Instruction fetch: owns the PC, drives imem req/ready
// and hands Decode either the fetched word or a bubble.
module ifetch_stage
  import ifetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [5:0]  NOP_OPCODE = NOP_OPCODE_C,
  parameter logic [5:0]  NOP_FUNCT  = NOP_FUNCT_C
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  JumpType,
  input  logic        CondSrc,
  input  logic        BranchCond,
  input  logic        BranchResult,
  input  logic        FPCond,
  input  logic [31:0] DecodePCPlusFour,
  input  logic [15:0] DecodeImm16,
  input  logic [25:0] DecodeImm26,
  input  logic [31:0] JumpRegData,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemReady,
  input  logic [31:0] ImemData,
  output logic [5:0]  NextOpCode,
  output logic [4:0]  NextRs1,
  output logic [4:0]  NextRs2,
  output logic [4:0]  NextRd,
  output logic [15:0] NextImmd,
  output logic [5:0]  NextFunct,
  output logic [31:0] NextPCPlusFour
);

  fetch_state_e r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_req_addr;
  logic [31:0]  r_skid;
  logic [31:0]  r_ir_pc4;
  logic [0:31]  r_ir;
  logic         r_ir_valid;

  logic         w_taken;
  logic         w_tk;
  logic [31:0]  w_target;
  logic [31:0]  w_pc4;
  logic         w_xfer;

  ifetch_target_gen u_tgt (
    .i_jump_type     (JumpType),
    .i_cond_src      (CondSrc),
    .i_branch_cond   (BranchCond),
    .i_branch_result (BranchResult),
    .i_fp_cond       (FPCond),
    .i_pc_plus4      (DecodePCPlusFour),
    .i_imm16         (DecodeImm16),
    .i_imm26         (DecodeImm26),
    .i_jr_data       (JumpRegData),
    .o_taken         (w_taken),
    .o_target        (w_target)
  );

  // Redirects only count while the pipe is moving
  assign w_tk     = w_taken & ~stall;
  assign w_pc4    = r_pc + 32'd4;
  assign ImemReq  = ~reset & (r_state != ST_HELD);
  assign ImemAddr = r_req_addr;
  assign w_xfer   = ImemReq & ImemReady;

  // Fetch FSM: PC, request address, IR and skid buffer
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_ISSUE;
      r_pc       <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_skid     <= '0;
      r_ir       <= '0;
      r_ir_pc4   <= '0;
      r_ir_valid <= 1'b0;
    end else begin
      unique case (r_state)
        ST_ISSUE: begin
          if (w_xfer) begin
            if (stall) begin
              r_skid  <= ImemData;
              r_pc    <= w_pc4;
              r_state <= ST_HELD;
            end else if (w_tk) begin
              r_ir_valid <= 1'b0;
              r_pc       <= w_target;
              r_req_addr <= w_target;
            end else begin
              r_ir       <= ImemData;
              r_ir_valid <= 1'b1;
              r_ir_pc4   <= w_pc4;
              r_pc       <= w_pc4;
              r_req_addr <= w_pc4;
            end
          end else if (w_tk) begin
            r_pc       <= w_target;
            r_ir_valid <= 1'b0;
            r_state    <= ST_DROP;
          end else if (!stall) begin
            r_ir_valid <= 1'b0;
          end
        end
        ST_HELD: begin
          if (!stall) begin
            r_state <= ST_ISSUE;
            if (w_tk) begin
              r_pc       <= w_target;
              r_req_addr <= w_target;
              r_ir_valid <= 1'b0;
            end else begin
              r_ir       <= r_skid;
              r_ir_valid <= 1'b1;
              r_ir_pc4   <= r_pc;
              r_req_addr <= r_pc;
            end
          end
        end
        ST_DROP: begin
          if (w_tk) r_pc <= w_target;
          if (w_xfer) begin
            r_state    <= ST_ISSUE;
            r_req_addr <= w_tk ? w_target : r_pc;
          end
        end
        default: r_state <= ST_ISSUE;
      endcase
    end
  end

  // Decode sees the IR fields or a NOP bubble
  always_comb begin
    NextOpCode     = NOP_OPCODE;
    NextRs1        = '0;
    NextRs2        = '0;
    NextRd         = '0;
    NextImmd       = '0;
    NextFunct      = NOP_FUNCT;
    NextPCPlusFour = '0;
    if (r_ir_valid) begin
      NextOpCode     = r_ir[0:5];
      NextRs1        = r_ir[6:10];
      NextRs2        = r_ir[11:15];
      NextRd         = r_ir[16:20];
      NextImmd       = r_ir[16:31];
      NextFunct      = r_ir[26:31];
      NextPCPlusFour = r_ir_pc4;
    end
  end

endmodule

// File: tb/tb_ifetch_stage.sv
// Directed bench for ifetch_stage.
// Inputs change on negedge; outputs sampled 1ns later.
module tb_ifetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [1:0]  JumpType;
  logic        CondSrc;
  logic        BranchCond;
  logic        BranchResult;
  logic        FPCond;
  logic [31:0] DecodePCPlusFour;
  logic [15:0] DecodeImm16;
  logic [25:0] DecodeImm26;
  logic [31:0] JumpRegData;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemReady;
  logic [31:0] ImemData;
  logic [5:0]  NextOpCode;
  logic [4:0]  NextRs1;
  logic [4:0]  NextRs2;
  logic [4:0]  NextRd;
  logic [15:0] NextImmd;
  logic [5:0]  NextFunct;
  logic [31:0] NextPCPlusFour;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] W0 = 32'h0062_2820;
  localparam logic [31:0] W1 = 32'h8C22_0010;
  localparam logic [31:0] W2 = 32'hAC45_FFFC;
  localparam logic [74:0] BUB =
    {6'h00, 5'd0, 5'd0, 5'd0, 16'h0, 6'h15, 32'h0};

  logic [74:0] nx;
  assign nx = {NextOpCode, NextRs1, NextRs2, NextRd,
               NextImmd, NextFunct, NextPCPlusFour};

  function automatic logic [74:0] fld(
    input logic [31:0] w, input logic [31:0] p4);
    return {w[31:26], w[25:21], w[20:16], w[15:11],
            w[15:0], w[5:0], p4};
  endfunction

  ifetch_stage dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .JumpType         (JumpType),
    .CondSrc          (CondSrc),
    .BranchCond       (BranchCond),
    .BranchResult     (BranchResult),
    .FPCond           (FPCond),
    .DecodePCPlusFour (DecodePCPlusFour),
    .DecodeImm16      (DecodeImm16),
    .DecodeImm26      (DecodeImm26),
    .JumpRegData      (JumpRegData),
    .ImemReq          (ImemReq),
    .ImemAddr         (ImemAddr),
    .ImemReady        (ImemReady),
    .ImemData         (ImemData),
    .NextOpCode       (NextOpCode),
    .NextRs1          (NextRs1),
    .NextRs2          (NextRs2),
    .NextRd           (NextRd),
    .NextImmd         (NextImmd),
    .NextFunct        (NextFunct),
    .NextPCPlusFour   (NextPCPlusFour)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    stall            = 1'b0;
    JumpType         = 2'b00;
    CondSrc          = 1'b0;
    BranchCond       = 1'b0;
    BranchResult     = 1'b0;
    FPCond           = 1'b0;
    DecodePCPlusFour = '0;
    DecodeImm16      = '0;
    DecodeImm26      = '0;
    JumpRegData      = '0;
    ImemReady        = 1'b0;
    ImemData         = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (ImemReq !== 1'b0) begin
      errors++;
      $display("FAIL rst_req got %b exp 0", ImemReq);
    end
    checks++;
    if (nx !== BUB) begin
      errors++;
      $display("FAIL rst_bubble got %h exp %h", nx, BUB);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({ImemReq, ImemAddr} !== {1'b1, 32'h0}) begin
      errors++;
      $display("FAIL rst_first_req got %b/%h exp 1/0",
               ImemReq, ImemAddr);
    end
  endtask

  task automatic test_zero_wait();
    logic [31:0] w [3];
    w[0] = W0; w[1] = W1; w[2] = W2;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ImemReady = (i < 3);
      ImemData  = (i < 3) ? w[i] : 32'h0;
      #1;
      checks++;
      if ({ImemReq, ImemAddr} !== {1'b1, 32'(4 * i)}) begin
        errors++;
        $display("FAIL zw_addr%0d got %b/%h exp 1/%h",
                 i, ImemReq, ImemAddr, 4 * i);
      end
      if (i > 0) begin
        checks++;
        if (nx !== fld(w[i-1], 32'(4 * i))) begin
          errors++;
          $display("FAIL zw_next%0d got %h exp %h",
                   i, nx, fld(w[i-1], 32'(4 * i)));
        end
      end
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] w [2];
    w[0] = W0; w[1] = W1;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        ImemReady = (c == 2);
        ImemData  = w[k];
        #1;
        checks++;
        if ({ImemReq, ImemAddr} !== {1'b1, 32'(4 * k)}) begin
          errors++;
          $display("FAIL ws_addr k%0d c%0d got %b/%h exp 1/%h",
                   k, c, ImemReq, ImemAddr, 4 * k);
        end
        checks++;
        if (k == 1 && c == 0) begin
          if (nx !== fld(W0, 32'h4)) begin
            errors++;
            $display("FAIL ws_instr0 got %h exp %h",
                     nx, fld(W0, 32'h4));
          end
        end else if (nx !== BUB) begin
          errors++;
          $display("FAIL ws_bubble k%0d c%0d got %h exp %h",
                   k, c, nx, BUB);
        end
      end
    end
    @(negedge clk);
    ImemReady = 1'b0;
    #1;
    checks++;
    if (nx !== fld(W1, 32'h8)) begin
      errors++;
      $display("FAIL ws_instr1 got %h exp %h",
               nx, fld(W1, 32'h8));
    end
  endtask

  task automatic test_stall_skid();
    do_reset();
    @(negedge clk);
    ImemReady = 1'b1; ImemData = W0;
    @(negedge clk);
    ImemReady = 1'b0; stall = 1'b1;
    #1;
    checks++;
    if (nx !== fld(W0, 32'h4)) begin
      errors++;
      $display("FAIL sk_hold0 got %h exp %h",
               nx, fld(W0, 32'h4));
    end
    @(negedge clk);
    ImemReady = 1'b1; ImemData = W1;
    #1;
    checks++;
    if ({ImemReq, ImemAddr} !== {1'b1, 32'h4}) begin
      errors++;
      $display("FAIL sk_wait_addr got %b/%h exp 1/4",
               ImemReq, ImemAddr);
    end
    @(negedge clk);
    ImemReady = 1'b0; ImemData = 32'h0;
    #1;
    checks++;
    if (ImemReq !== 1'b0) begin
      errors++;
      $display("FAIL sk_held_req got %b exp 0", ImemReq);
    end
    checks++;
    if (nx !== fld(W0, 32'h4)) begin
      errors++;
      $display("FAIL sk_held_next got %h exp %h",
               nx, fld(W0, 32'h4));
    end
    @(negedge clk);
    stall = 1'b0;
    #1;
    checks++;
    if ({ImemReq, nx} !== {1'b0, fld(W0, 32'h4)}) begin
      errors++;
      $display("FAIL sk_release got %b/%h exp 0/%h",
               ImemReq, nx, fld(W0, 32'h4));
    end
    @(negedge clk);
    #1;
    checks++;
    if (nx !== fld(W1, 32'h8)) begin
      errors++;
      $display("FAIL sk_skid_out got %h exp %h",
               nx, fld(W1, 32'h8));
    end
    checks++;
    if ({ImemReq, ImemAddr} !== {1'b1, 32'h8}) begin
      errors++;
      $display("FAIL sk_resume got %b/%h exp 1/8",
               ImemReq, ImemAddr);
    end
  endtask

  task automatic test_branch();
    do_reset();
    @(negedge clk);
    ImemReady = 1'b1; ImemData = W0;
    @(negedge clk);
    ImemData = W1;
    JumpType = 2'b01; CondSrc = 1'b0;
    BranchResult = 1'b1; BranchCond = 1'b1;
    DecodePCPlusFour = 32'h100; DecodeImm16 = 16'hFFF0;
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (ImemAddr !== 32'hF0) begin
      errors++;
      $display("FAIL br_target got %h exp f0", ImemAddr);
    end
    checks++;
    if (nx !== BUB) begin
      errors++;
      $display("FAIL br_squash got %h exp %h", nx, BUB);
    end
    @(negedge clk);
    ImemReady = 1'b1; ImemData = W2;
    @(negedge clk);
    ImemData = W0;
    JumpType = 2'b01; CondSrc = 1'b0;
    BranchResult = 1'b1; BranchCond = 1'b0;
    #1;
    checks++;
    if ({ImemAddr, nx} !== {32'hF4, fld(W2, 32'hF4)}) begin
      errors++;
      $display("FAIL br_after got %h/%h exp f4/%h",
               ImemAddr, nx, fld(W2, 32'hF4));
    end
    @(negedge clk);
    ImemData = W1;
    JumpType = 2'b01; CondSrc = 1'b1; FPCond = 1'b0;
    BranchResult = 1'b1; BranchCond = 1'b0;
    DecodePCPlusFour = 32'h200; DecodeImm16 = 16'h0010;
    #1;
    checks++;
    if ({ImemAddr, nx} !== {32'hF8, fld(W0, 32'hF8)}) begin
      errors++;
      $display("FAIL br_not_taken got %h/%h exp f8/%h",
               ImemAddr, nx, fld(W0, 32'hF8));
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if ({ImemAddr, nx} !== {32'h210, BUB}) begin
      errors++;
      $display("FAIL br_fpcond got %h/%h exp 210/%h",
               ImemAddr, nx, BUB);
    end
  endtask

  task automatic test_jr_drop();
    do_reset();
    @(negedge clk);
    ImemReady = 1'b1; ImemData = W0;
    @(negedge clk);
    ImemReady = 1'b0;
    JumpType = 2'b11; JumpRegData = 32'h2000;
    @(negedge clk);
    idle();
    #1;
    checks++;
    if ({ImemReq, ImemAddr, nx} !== {1'b1, 32'h4, BUB}) begin
      errors++;
      $display("FAIL jr_drop got %b/%h/%h exp 1/4/%h",
               ImemReq, ImemAddr, nx, BUB);
    end
    @(negedge clk);
    ImemReady = 1'b1; ImemData = W1;
    #1;
    checks++;
    if (ImemAddr !== 32'h4) begin
      errors++;
      $display("FAIL jr_old_addr got %h exp 4", ImemAddr);
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if ({ImemAddr, nx} !== {32'h2000, BUB}) begin
      errors++;
      $display("FAIL jr_new_addr got %h/%h exp 2000/%h",
               ImemAddr, nx, BUB);
    end
  endtask

  task automatic test_drop_reset();
    do_reset();
    @(negedge clk);
    JumpType = 2'b11; JumpRegData = 32'h2000;
    @(negedge clk);
    JumpType = 2'b10;
    DecodePCPlusFour = 32'h300; DecodeImm26 = 26'h3FF_FFFC;
    #1;
    checks++;
    if ({ImemReq, ImemAddr} !== {1'b1, 32'h0}) begin
      errors++;
      $display("FAIL dr_hold got %b/%h exp 1/0",
               ImemReq, ImemAddr);
    end
    @(negedge clk);
    idle();
    ImemReady = 1'b1;
    @(negedge clk);
    idle();
    JumpType = 2'b11; JumpRegData = 32'h2000;
    #1;
    checks++;
    if (ImemAddr !== 32'h2FC) begin
      errors++;
      $display("FAIL dr_last_wins got %h exp 2fc", ImemAddr);
    end
    @(negedge clk);
    idle();
    reset = 1'b1;
    #1;
    checks++;
    if ({ImemReq, ImemAddr} !== {1'b0, 32'h2FC}) begin
      errors++;
      $display("FAIL dr_in_drop got %b/%h exp 0/2fc",
               ImemReq, ImemAddr);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({ImemReq, nx} !== {1'b0, BUB}) begin
      errors++;
      $display("FAIL dr_reset got %b/%h exp 0/%h",
               ImemReq, nx, BUB);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({ImemReq, ImemAddr} !== {1'b1, 32'h0}) begin
      errors++;
      $display("FAIL dr_restart got %b/%h exp 1/0",
               ImemReq, ImemAddr);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    @(negedge clk);
    JumpType = 2'b11; JumpRegData = 32'hFFFF_FFFC;
    @(negedge clk);
    idle();
    ImemReady = 1'b1;
    @(negedge clk);
    ImemData = W1;
    #1;
    checks++;
    if (ImemAddr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_top got %h exp fffffffc", ImemAddr);
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if ({ImemAddr, nx} !== {32'h0, fld(W1, 32'h0)}) begin
      errors++;
      $display("FAIL wrap_zero got %h/%h exp 0/%h",
               ImemAddr, nx, fld(W1, 32'h0));
    end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_stall_skid();
    test_branch();
    test_jr_drop();
    test_drop_reset();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
